// File: rtl/contactor_sequencer.sv
// Round-robin close/open sequencer for eight contactors.
// Supervises feedback, settles between moves, latches faults.
module contactor_sequencer #(
  parameter int unsigned FB_TIMEOUT = 1000,
  parameter int unsigned SETTLE     = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_req,
  input  logic [7:0] i_permit,
  input  logic [7:0] i_fb,
  input  logic       i_fault_clr,
  output logic [7:0] o_cmd,
  output logic       o_busy,
  output logic       o_fault,
  output logic [2:0] o_fault_id,
  output logic       o_reject
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLOSE_WAIT,
    S_OPEN_WAIT,
    S_SETTLE,
    S_FAULT
  } state_t;

  localparam logic [15:0] TO_LAST =
    16'(FB_TIMEOUT - 1);
  localparam logic [15:0] ST_LAST =
    16'(SETTLE - 1);

  state_t          state;
  logic [2:0]      ptr;
  logic [2:0]      gnt;
  logic [15:0]     cnt;
  logic [7:0][2:0] cd;

  logic [7:0]  p_open;
  logic [7:0]  p_close;
  logic [7:0]  refuse;
  logic [7:0]  mism;
  logic [7:0]  cd_zero;
  logic [15:0] cnt_inc;

  logic       open_hit;
  logic       close_hit;
  logic       ref_hit;
  logic       mis_hit;
  logic [2:0] open_idx;
  logic [2:0] close_idx;
  logic [2:0] ref_idx;
  logic [2:0] mis_idx;
  logic [2:0] idx;

  // Classify each contactor: pending move,
  // refused close, or feedback disagreement.
  always_comb begin
    cd_zero = '0;
    for (int i = 0; i < 8; i++) begin
      cd_zero[i] = (cd[i] == 3'd0);
    end
    p_open  = o_cmd & ~(i_req & i_permit);
    p_close = i_req & ~o_cmd & i_permit;
    refuse  = i_req & ~o_cmd & ~i_permit
            & cd_zero;
    mism    = i_fb ^ o_cmd;
    if (state != S_IDLE) begin
      mism[gnt] = 1'b0;
    end
    cnt_inc = (cnt == 16'hFFFF) ? cnt
            : cnt + 16'd1;
  end

  // First pending open/close at or above ptr,
  // scanned downward so the nearest one wins.
  always_comb begin
    open_hit  = 1'b0;
    open_idx  = '0;
    close_hit = 1'b0;
    close_idx = '0;
    idx       = '0;
    for (int n = 7; n >= 0; n--) begin
      idx = ptr + 3'(n);
      if (p_open[idx]) begin
        open_hit = 1'b1;
        open_idx = idx;
      end
      if (p_close[idx]) begin
        close_hit = 1'b1;
        close_idx = idx;
      end
    end
  end

  // Lowest-index refused close and mismatch.
  always_comb begin
    ref_hit = 1'b0;
    ref_idx = '0;
    mis_hit = 1'b0;
    mis_idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (refuse[i]) begin
        ref_hit = 1'b1;
        ref_idx = 3'(i);
      end
      if (mism[i]) begin
        mis_hit = 1'b1;
        mis_idx = 3'(i);
      end
    end
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= S_IDLE;
      ptr        <= '0;
      gnt        <= '0;
      cnt        <= '0;
      cd         <= '0;
      o_cmd      <= '0;
      o_busy     <= 1'b0;
      o_fault    <= 1'b0;
      o_fault_id <= '0;
      o_reject   <= 1'b0;
    end else begin
      o_reject <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        if (cd[i] != 3'd0) begin
          cd[i] <= cd[i] - 3'd1;
        end
      end
      if (state == S_FAULT) begin
        if (i_fault_clr && i_fb == 8'h00) begin
          state   <= S_IDLE;
          o_busy  <= 1'b0;
          o_fault <= 1'b0;
        end
      end else if (mis_hit) begin
        state      <= S_FAULT;
        o_cmd      <= '0;
        o_fault_id <= mis_idx;
        o_busy     <= 1'b1;
        o_fault    <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (open_hit) begin
              o_cmd[open_idx] <= 1'b0;
              gnt    <= open_idx;
              ptr    <= open_idx + 3'd1;
              cnt    <= '0;
              state  <= S_OPEN_WAIT;
              o_busy <= 1'b1;
            end else if (close_hit) begin
              o_cmd[close_idx] <= 1'b1;
              gnt    <= close_idx;
              ptr    <= close_idx + 3'd1;
              cnt    <= '0;
              state  <= S_CLOSE_WAIT;
              o_busy <= 1'b1;
            end else if (ref_hit) begin
              o_reject    <= 1'b1;
              cd[ref_idx] <= 3'd7;
            end
          end
          S_CLOSE_WAIT: begin
            if (!i_permit[gnt]) begin
              o_cmd[gnt] <= 1'b0;
              cnt        <= '0;
              state      <= S_OPEN_WAIT;
            end else if (i_fb[gnt]) begin
              cnt   <= '0;
              state <= S_SETTLE;
            end else if (cnt == TO_LAST) begin
              o_cmd      <= '0;
              o_fault_id <= gnt;
              o_fault    <= 1'b1;
              state      <= S_FAULT;
            end else begin
              cnt <= cnt_inc;
            end
          end
          S_OPEN_WAIT: begin
            if (!i_fb[gnt]) begin
              cnt   <= '0;
              state <= S_SETTLE;
            end else if (cnt == TO_LAST) begin
              o_cmd      <= '0;
              o_fault_id <= gnt;
              o_fault    <= 1'b1;
              state      <= S_FAULT;
            end else begin
              cnt <= cnt_inc;
            end
          end
          S_SETTLE: begin
            if (cnt == ST_LAST) begin
              state  <= S_IDLE;
              o_busy <= 1'b0;
            end else begin
              cnt <= cnt_inc;
            end
          end
          default: begin
            state  <= S_IDLE;
            o_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_contactor_sequencer.sv
// Bench for contactor_sequencer: vector table,
// directed corner cases, random run vs model.
module tb_contactor_sequencer;

  localparam int FBT = 10;
  localparam int ST  = 16;

  localparam int P_IDLE   = 0;
  localparam int P_CLOSE  = 1;
  localparam int P_OPEN   = 2;
  localparam int P_SETTLE = 3;
  localparam int P_FAULT  = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = '0;
  logic [7:0] permit = 8'hFF;
  logic [7:0] fb = '0;
  logic       clr = 1'b0;
  logic [7:0] o_cmd;
  logic       o_busy;
  logic       o_fault;
  logic [2:0] o_fault_id;
  logic       o_reject;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  contactor_sequencer #(
    .FB_TIMEOUT(FBT),
    .SETTLE(ST)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_req(req),
    .i_permit(permit),
    .i_fb(fb),
    .i_fault_clr(clr),
    .o_cmd(o_cmd),
    .o_busy(o_busy),
    .o_fault(o_fault),
    .o_fault_id(o_fault_id),
    .o_reject(o_reject)
  );

  // reference model
  bit [7:0] m_cmd;
  int m_ph, m_ptr, m_k, m_el, m_rem, m_id;
  bit m_rej;
  int m_now = 0;
  int m_last [8];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h",
               nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_cmd = '0;
    m_ph  = P_IDLE;
    m_ptr = 0;
    m_k   = 0;
    m_el  = 0;
    m_rem = 0;
    m_id  = 0;
    m_rej = 0;
    for (int j = 0; j < 8; j++) m_last[j] = -100;
  endtask

  function automatic int first_rr(
      input bit [7:0] v, input int p);
    for (int n = 0; n < 8; n++) begin
      if (v[(p + n) % 8]) return (p + n) % 8;
    end
    return -1;
  endfunction

  task automatic go_fault(input int j);
    m_ph  = P_FAULT;
    m_cmd = '0;
    m_id  = j;
  endtask

  task automatic model_step();
    int o, c;
    m_now++;
    m_rej = 0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (m_ph == P_FAULT) begin
      if (clr && fb == 8'h00) m_ph = P_IDLE;
      return;
    end
    for (int j = 0; j < 8; j++) begin
      if (fb[j] != m_cmd[j] &&
          (m_ph == P_IDLE || j != m_k)) begin
        go_fault(j);
        return;
      end
    end
    case (m_ph)
      P_IDLE: begin
        o = first_rr(m_cmd & ~(req & permit), m_ptr);
        c = first_rr(req & ~m_cmd & permit, m_ptr);
        if (o >= 0) begin
          m_cmd[o] = 1'b0;
          m_k = o;
          m_ptr = (o + 1) % 8;
          m_el = 0;
          m_ph = P_OPEN;
        end else if (c >= 0) begin
          m_cmd[c] = 1'b1;
          m_k = c;
          m_ptr = (c + 1) % 8;
          m_el = 0;
          m_ph = P_CLOSE;
        end else begin
          for (int j = 0; j < 8; j++) begin
            if (req[j] && !m_cmd[j] && !permit[j]
                && m_now - m_last[j] >= 8) begin
              m_rej = 1;
              m_last[j] = m_now;
              break;
            end
          end
        end
      end
      P_CLOSE: begin
        if (!permit[m_k]) begin
          m_cmd[m_k] = 1'b0;
          m_el = 0;
          m_ph = P_OPEN;
        end else if (fb[m_k]) begin
          m_rem = ST;
          m_ph = P_SETTLE;
        end else begin
          m_el++;
          if (m_el >= FBT) go_fault(m_k);
        end
      end
      P_OPEN: begin
        if (!fb[m_k]) begin
          m_rem = ST;
          m_ph = P_SETTLE;
        end else begin
          m_el++;
          if (m_el >= FBT) go_fault(m_k);
        end
      end
      default: begin
        m_rem--;
        if (m_rem == 0) m_ph = P_IDLE;
      end
    endcase
  endtask

  task automatic model_cmp();
    logic [13:0] act, exp;
    act = {o_cmd, o_busy, o_fault,
           o_fault_id, o_reject};
    exp = {m_cmd, m_ph != P_IDLE,
           m_ph == P_FAULT, m_id[2:0], m_rej};
    chk("model", 32'(act), 32'(exp));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    model_cmp();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_cmd", 32'(o_cmd), 0);
    chk("rst_flags",
        32'({o_busy, o_fault, o_reject}), 0);
    model_reset();
    req = '0;
    permit = 8'hFF;
    fb = '0;
    clr = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  typedef struct {
    int         n;
    logic [7:0] req;
    logic [7:0] permit;
    logic [7:0] fb;
    logic [7:0] cmd;
    logic       busy;
    logic       rej;
  } vec_t;

  vec_t tbl [12];

  logic [7:0] hist [8];
  int         dly  [8];
  bit [7:0]   stuck;
  int         b;

  initial begin
    tbl[0]  = '{1,  8'h08, 8'hFF, 8'h00, 8'h08, 1, 0};
    tbl[1]  = '{2,  8'h08, 8'hFF, 8'h00, 8'h08, 1, 0};
    tbl[2]  = '{16, 8'h08, 8'hFF, 8'h08, 8'h08, 1, 0};
    tbl[3]  = '{2,  8'h08, 8'hFF, 8'h08, 8'h08, 0, 0};
    tbl[4]  = '{1,  8'h00, 8'hFF, 8'h08, 8'h00, 1, 0};
    tbl[5]  = '{16, 8'h00, 8'hFF, 8'h00, 8'h00, 1, 0};
    tbl[6]  = '{2,  8'h00, 8'hFF, 8'h00, 8'h00, 0, 0};
    tbl[7]  = '{1,  8'h04, 8'hFB, 8'h00, 8'h00, 0, 1};
    tbl[8]  = '{7,  8'h04, 8'hFB, 8'h00, 8'h00, 0, 0};
    tbl[9]  = '{1,  8'h04, 8'hFB, 8'h00, 8'h00, 0, 1};
    tbl[10] = '{1,  8'h04, 8'hFF, 8'h00, 8'h04, 1, 0};
    tbl[11] = '{1,  8'h04, 8'hFF, 8'h04, 8'h04, 1, 0};

    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("init_cmd", 32'(o_cmd), 0);
    chk("init_busy", 32'(o_busy), 0);
    chk("init_fault", 32'(o_fault), 0);
    chk("init_id", 32'(o_fault_id), 0);
    chk("init_rej", 32'(o_reject), 0);
    rst_n = 1'b1;

    // vector table: close, open, refuse, grant
    for (int r = 0; r < 12; r++) begin
      for (int c = 0; c < tbl[r].n; c++) begin
        req    = tbl[r].req;
        permit = tbl[r].permit;
        fb     = tbl[r].fb;
        tick();
        chk($sformatf("vec%0d", r),
            32'({o_cmd, o_busy, o_fault, o_reject}),
            32'({tbl[r].cmd, tbl[r].busy, 1'b0,
                 tbl[r].rej}));
      end
    end

    // feedback timeout on B
    do_reset();
    req = 8'h02;
    tick();
    chk("to_cmd", 32'(o_cmd), 32'h02);
    repeat (9) tick();
    chk("to_early", 32'(o_fault), 0);
    tick();
    chk("to_fault", 32'({o_fault, o_busy}), 32'h3);
    chk("to_cmd0", 32'(o_cmd), 0);
    chk("to_id", 32'(o_fault_id), 1);
    req = '0;
    clr = 1'b1;
    tick();
    chk("to_clr", 32'({o_fault, o_busy}), 0);
    chk("to_idhold", 32'(o_fault_id), 1);
    clr = 1'b0;

    // idle feedback mismatch, lowest index
    do_reset();
    fb = 8'h24;
    tick();
    chk("mm_fault", 32'(o_fault), 1);
    chk("mm_id", 32'(o_fault_id), 2);
    clr = 1'b1;
    tick();
    chk("mm_hold", 32'(o_fault), 1);
    fb = '0;
    tick();
    chk("mm_clr", 32'(o_fault), 0);
    clr = 1'b0;

    // permit loss after close and during wait
    do_reset();
    req = 8'h10;
    tick();
    chk("pl_cmd", 32'(o_cmd), 32'h10);
    fb = 8'h10;
    tick();
    repeat (15) tick();
    chk("pl_settle", 32'(o_busy), 1);
    tick();
    chk("pl_idle", 32'(o_busy), 0);
    permit = 8'hEF;
    tick();
    chk("pl_open", 32'({o_cmd, o_busy}),
        32'({8'h00, 1'b1}));
    fb = '0;
    tick();
    repeat (16) tick();
    chk("pl_done", 32'(o_busy), 0);
    permit = 8'hFF;
    tick();
    chk("pd_cmd", 32'(o_cmd), 32'h10);
    permit = 8'hEF;
    tick();
    chk("pd_drop", 32'({o_cmd, o_busy}),
        32'({8'h00, 1'b1}));
    tick();
    repeat (16) tick();
    chk("pd_done", 32'(o_busy), 0);

    // round-robin A then H
    do_reset();
    req = 8'h81;
    tick();
    chk("rr_a", 32'(o_cmd), 32'h01);
    fb = 8'h01;
    repeat (17) tick();
    chk("rr_wait", 32'({o_cmd, o_busy}),
        32'({8'h01, 1'b0}));
    tick();
    chk("rr_h", 32'(o_cmd), 32'h81);
    fb = 8'h81;
    repeat (17) tick();
    req = '0;
    tick();
    fb = o_cmd;
    repeat (17) tick();
    tick();
    fb = o_cmd;
    repeat (17) tick();
    chk("rr_open", 32'({o_cmd, o_busy}), 0);

    // reset in the middle of a close wait
    do_reset();
    req = 8'h01;
    tick();
    chk("ra_cmd", 32'(o_cmd), 32'h01);
    rst_n = 1'b0;
    #1;
    chk("ra_async",
        32'({o_cmd, o_busy, o_fault}), 0);
    do_reset();

    // randomized run against the model
    for (int j = 0; j < 8; j++) begin
      hist[j] = '0;
      dly[j]  = 1;
    end
    stuck = '0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int j = 7; j > 0; j--)
        hist[j] = hist[j-1];
      hist[0] = o_cmd;
      for (int j = 0; j < 8; j++) begin
        if ($urandom_range(0, 49) == 0)
          dly[j] = $urandom_range(1, 4);
        if (!stuck[j]) fb[j] = hist[dly[j]][j];
      end
      b = $urandom_range(0, 7);
      if ($urandom_range(0, 199) == 0)
        stuck[b] = ~stuck[b];
      if (o_fault && $urandom_range(0, 9) == 0)
        stuck = '0;
      if ($urandom_range(0, 299) == 0)
        fb[b] = ~fb[b];
      b = $urandom_range(0, 7);
      if ($urandom_range(0, 19) == 0)
        req[b] = ~req[b];
      b = $urandom_range(0, 7);
      if ($urandom_range(0, 39) == 0)
        permit[b] = 1'b0;
      else if ($urandom_range(0, 9) == 0)
        permit[b] = 1'b1;
      clr = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 999) == 0) begin
        do_reset();
        stuck = '0;
      end else begin
        tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
